dtim_banked: RTL and testbench

//   Banked, dual-requester data tightly-integrated memory for the LSU. Splits DTIM_RANGE

---
 rtl/dtim_banked_pkg.sv | 32 +++
 rtl/dtim_banked_arb.sv | 68 ++++++
 rtl/dtim_banked.sv | 212 +++++++++++++++++++++
 tb/tb_dtim_banked.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dtim_banked_pkg.sv
// dtim_banked_pkg: shared definitions for the banked data TIM.
//   LLEN / PA_BITS / DTIM_RANGE : data width, physical address width, DTIM size in bytes
//   NBYTES / OFFSET             : bytes per word and byte-offset bits inside a word
//   dtim_req_t                  : one requester's access (valid, write, adr, wdata, bmask)
//   byte_parity()               : even parity per byte of a data word
package dtim_banked_pkg;

  localparam int LLEN       = 64;
  localparam int PA_BITS    = 32;
  localparam int DTIM_RANGE = 4096;
  localparam int NBYTES     = LLEN / 8;
  localparam int OFFSET     = $clog2(NBYTES);

  typedef struct packed {
    logic                valid;
    logic                write;
    logic [PA_BITS-1:0]  adr;
    logic [LLEN-1:0]     wdata;
    logic [NBYTES-1:0]   bmask;
  } dtim_req_t;

  // One even-parity bit per byte: the stored bit makes the byte plus parity have even weight.
  function automatic logic [NBYTES-1:0] byte_parity(input logic [LLEN-1:0] data);
    logic [NBYTES-1:0] p;
    p = '0;
    for (int k = 0; k < NBYTES; k++) begin
      p[k] = ^data[8*k +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/dtim_banked_arb.sv
// dtim_banked_arb: per-cycle bank arbitration between the LSU and the DMA port.
//   clk, reset          : clock, synchronous active-high reset
//   lsu_valid_i/bank_i  : LSU request active and its target bank
//   dma_valid_i/bank_i  : DMA request valid and its target bank
//   lsu_gnt_o/dma_gnt_o : requester proceeds to its bank this cycle
//   lsu_stall_o         : LSU lost a conflict and must hold its request
//   dma_ready_o         : DMA request accepted (when dma_valid_i)
// On a same-bank conflict the LSU wins until the DMA has lost STARVE_LIMIT times in a
// row; the next conflict then goes to the DMA and the loss count restarts.
module dtim_banked_arb
  import dtim_banked_pkg::*;
#(
  parameter int NBANKS       = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      lsu_valid_i,
  input  logic [$clog2(NBANKS)-1:0] lsu_bank_i,
  input  logic                      dma_valid_i,
  input  logic [$clog2(NBANKS)-1:0] dma_bank_i,
  output logic                      lsu_gnt_o,
  output logic                      dma_gnt_o,
  output logic                      lsu_stall_o,
  output logic                      dma_ready_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             conflict_s;

  assign conflict_s = lsu_valid_i & dma_valid_i & (lsu_bank_i == dma_bank_i);

  // Grant decision and next starvation count.
  always_comb begin
    lsu_gnt_o   = lsu_valid_i;
    dma_gnt_o   = dma_valid_i;
    lsu_stall_o = 1'b0;
    dma_ready_o = 1'b1;
    starve_d    = '0;
    if (conflict_s) begin
      if (starve_q < CNT_W'(STARVE_LIMIT)) begin
        // Only reachable below the limit, so the count saturates at STARVE_LIMIT.
        dma_gnt_o   = 1'b0;
        dma_ready_o = 1'b0;
        starve_d    = starve_q + CNT_W'(1);
      end else begin
        lsu_gnt_o   = 1'b0;
        lsu_stall_o = 1'b1;
        starve_d    = '0;
      end
    end else begin
      // DMA idle or accepted without contention: the loss streak is broken.
      starve_d = '0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/dtim_banked.sv
// dtim_banked: banked, dual-requester data TIM shared by the LSU and a DMA/bus port.
//   clk, reset   : clock, synchronous active-high reset
//   LsuCe        : LSU access enable; 0 holds LsuReadData
//   FlushW       : suppresses an LSU write (trap)
//   LsuRW        : [1]=read, [0]=write, 00=idle
//   LsuAdr/LsuWData/LsuBMask : LSU byte address, write data, byte enables
//   LsuReadData  : LSU read word, valid the cycle after a granted read, held otherwise
//   LsuStall     : LSU lost arbitration this cycle
//   DmaValid/DmaReady/DmaWrite/DmaAdr/DmaWData/DmaBMask : DMA request handshake
//   DmaRValid/DmaRData : DMA read response, one cycle after acceptance
//   ParityErr    : read-return parity error pulse
// Words are interleaved over NBANKS single-port banks (bank = word index mod NBANKS).
// Optional feature macro DTIM_PARITY_EN: each bank keeps one even-parity bit per byte,
// written with the masked bytes and checked on every granted read return. Without it
// ParityErr is tied low.
module dtim_banked
  import dtim_banked_pkg::*;
#(
  parameter int NBANKS       = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               LsuCe,
  input  logic               FlushW,
  input  logic [1:0]         LsuRW,
  input  logic [PA_BITS-1:0] LsuAdr,
  input  logic [LLEN-1:0]    LsuWData,
  input  logic [NBYTES-1:0]  LsuBMask,
  output logic [LLEN-1:0]    LsuReadData,
  output logic               LsuStall,
  input  logic               DmaValid,
  output logic               DmaReady,
  input  logic               DmaWrite,
  input  logic [PA_BITS-1:0] DmaAdr,
  input  logic [LLEN-1:0]    DmaWData,
  input  logic [NBYTES-1:0]  DmaBMask,
  output logic               DmaRValid,
  output logic [LLEN-1:0]    DmaRData,
  output logic               ParityErr
);

  localparam int BANK_W = $clog2(NBANKS);
  localparam int ROWS   = DTIM_RANGE / NBYTES / NBANKS;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int ADR_HI = OFFSET + BANK_W + ROW_W;

  dtim_req_t         lsu_req_s, dma_req_s;
  logic [BANK_W-1:0] lsu_bank_s, dma_bank_s;
  logic [ROW_W-1:0]  lsu_row_s, dma_row_s;
  logic              lsu_gnt_s, dma_gnt_s;
  logic [LLEN-1:0]   bank_rdata_s [NBANKS];
  logic [LLEN-1:0]   lsu_rdata_s, dma_rdata_s;
  logic              lsu_rd_q, dma_rv_q;
  logic [BANK_W-1:0] lsu_sel_q, dma_sel_q;
  logic [LLEN-1:0]   lsu_hold_q, dma_hold_q;
  logic              unused_s;
`ifdef DTIM_PARITY_EN
  logic [NBANKS-1:0] bank_perr_s;
`endif

  // A flushed LSU write still occupies its bank for the cycle; it just does not store.
  assign lsu_req_s = '{valid: LsuCe & |LsuRW, write: LsuRW[0] & ~FlushW,
                       adr: LsuAdr, wdata: LsuWData, bmask: LsuBMask};
  assign dma_req_s = '{valid: DmaValid, write: DmaWrite,
                       adr: DmaAdr, wdata: DmaWData, bmask: DmaBMask};

  assign lsu_bank_s = lsu_req_s.adr[OFFSET +: BANK_W];
  assign dma_bank_s = dma_req_s.adr[OFFSET +: BANK_W];
  assign lsu_row_s  = lsu_req_s.adr[OFFSET + BANK_W +: ROW_W];
  assign dma_row_s  = dma_req_s.adr[OFFSET + BANK_W +: ROW_W];

  // Byte offset and bits above the DTIM window do not select storage.
  assign unused_s = ^{lsu_req_s.adr[OFFSET-1:0], lsu_req_s.adr[PA_BITS-1:ADR_HI],
                      dma_req_s.adr[OFFSET-1:0], dma_req_s.adr[PA_BITS-1:ADR_HI]};

  dtim_banked_arb #(
    .NBANKS       (NBANKS),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .lsu_valid_i (lsu_req_s.valid),
    .lsu_bank_i  (lsu_bank_s),
    .dma_valid_i (dma_req_s.valid),
    .dma_bank_i  (dma_bank_s),
    .lsu_gnt_o   (lsu_gnt_s),
    .dma_gnt_o   (dma_gnt_s),
    .lsu_stall_o (LsuStall),
    .dma_ready_o (DmaReady)
  );

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [LLEN-1:0]   mem_q [ROWS];
    logic [LLEN-1:0]   rdata_q;
    logic              en_s, we_s;
    logic [ROW_W-1:0]  row_s;
    logic [LLEN-1:0]   wdata_s;
    logic [NBYTES-1:0] bmask_s;

    // Bank port mux: arbitration guarantees at most one granted requester per bank.
    always_comb begin
      en_s    = 1'b0;
      we_s    = 1'b0;
      row_s   = '0;
      wdata_s = '0;
      bmask_s = '0;
      if (lsu_gnt_s && (lsu_bank_s == BANK_W'(b))) begin
        en_s    = 1'b1;
        we_s    = lsu_req_s.write;
        row_s   = lsu_row_s;
        wdata_s = lsu_req_s.wdata;
        bmask_s = lsu_req_s.bmask;
      end else if (dma_gnt_s && (dma_bank_s == BANK_W'(b))) begin
        en_s    = 1'b1;
        we_s    = dma_req_s.write;
        row_s   = dma_row_s;
        wdata_s = dma_req_s.wdata;
        bmask_s = dma_req_s.bmask;
      end else begin
        en_s = 1'b0;
      end
    end

    // Single-port storage: byte-masked write or synchronous read.
    always_ff @(posedge clk) begin
      if (en_s) begin
        if (we_s) begin
          for (int k = 0; k < NBYTES; k++) begin
            if (bmask_s[k]) begin
              mem_q[row_s][8*k +: 8] <= wdata_s[8*k +: 8];
            end
          end
        end else begin
          rdata_q <= mem_q[row_s];
        end
      end
    end

    assign bank_rdata_s[b] = rdata_q;

`ifdef DTIM_PARITY_EN
    logic [NBYTES-1:0] par_q [ROWS];
    logic [NBYTES-1:0] rpar_q;
    logic [NBYTES-1:0] wpar_s;

    assign wpar_s = byte_parity(wdata_s);

    // Parity side-array, written and read in lockstep with the data array.
    always_ff @(posedge clk) begin
      if (en_s) begin
        if (we_s) begin
          for (int k = 0; k < NBYTES; k++) begin
            if (bmask_s[k]) begin
              par_q[row_s][k] <= wpar_s[k];
            end
          end
        end else begin
          rpar_q <= par_q[row_s];
        end
      end
    end

    assign bank_perr_s[b] = |(rpar_q ^ byte_parity(rdata_q));
`endif
  end

  // Return muxes: fresh bank data the cycle after a granted read, else the held word.
  assign lsu_rdata_s = lsu_rd_q ? bank_rdata_s[lsu_sel_q] : lsu_hold_q;
  assign dma_rdata_s = dma_rv_q ? bank_rdata_s[dma_sel_q] : dma_hold_q;

  // Registered grant/bank-select per requester and the held read words.
  always_ff @(posedge clk) begin
    if (reset) begin
      lsu_rd_q   <= 1'b0;
      dma_rv_q   <= 1'b0;
      lsu_sel_q  <= '0;
      dma_sel_q  <= '0;
      lsu_hold_q <= '0;
      dma_hold_q <= '0;
    end else begin
      lsu_rd_q   <= lsu_gnt_s & LsuRW[1];
      dma_rv_q   <= dma_gnt_s & ~dma_req_s.write;
      lsu_sel_q  <= lsu_gnt_s ? lsu_bank_s : lsu_sel_q;
      dma_sel_q  <= dma_gnt_s ? dma_bank_s : dma_sel_q;
      lsu_hold_q <= lsu_rdata_s;
      dma_hold_q <= dma_rdata_s;
    end
  end

  // Outputs are forced quiet while reset is high, so a response whose request was
  // accepted just before reset never shows up as a DmaRValid pulse.
  always_comb begin
    LsuReadData = '0;
    DmaRData    = '0;
    DmaRValid   = 1'b0;
    ParityErr   = 1'b0;
    if (reset) begin
      DmaRValid = 1'b0;
    end else begin
      LsuReadData = lsu_rdata_s;
      DmaRData    = dma_rdata_s;
      DmaRValid   = dma_rv_q;
`ifdef DTIM_PARITY_EN
      ParityErr   = (lsu_rd_q & bank_perr_s[lsu_sel_q]) | (dma_rv_q & bank_perr_s[dma_sel_q]);
`else
      ParityErr   = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_dtim_banked.sv
module tb_dtim_banked;
  import dtim_banked_pkg::*;

  localparam int NB    = 2;
  localparam int SL    = 4;
  localparam int WORDS = DTIM_RANGE / NBYTES;

  logic               clk = 1'b0;
  logic               reset;
  logic               LsuCe, FlushW, DmaValid, DmaWrite;
  logic [1:0]         LsuRW;
  logic [PA_BITS-1:0] LsuAdr, DmaAdr;
  logic [LLEN-1:0]    LsuWData, DmaWData;
  logic [NBYTES-1:0]  LsuBMask, DmaBMask;
  logic [LLEN-1:0]    LsuReadData, DmaRData;
  logic               LsuStall, DmaReady, DmaRValid, ParityErr;

  dtim_banked #(.NBANKS(NB), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset), .LsuCe(LsuCe), .FlushW(FlushW), .LsuRW(LsuRW),
    .LsuAdr(LsuAdr), .LsuWData(LsuWData), .LsuBMask(LsuBMask), .LsuReadData(LsuReadData),
    .LsuStall(LsuStall), .DmaValid(DmaValid), .DmaReady(DmaReady), .DmaWrite(DmaWrite),
    .DmaAdr(DmaAdr), .DmaWData(DmaWData), .DmaBMask(DmaBMask), .DmaRValid(DmaRValid),
    .DmaRData(DmaRData), .ParityErr(ParityErr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: plain word array, known flags, DMA loss streak, LSU held word.
  logic [LLEN-1:0] mdl [WORDS];
  bit              known [WORDS];
  int              starve = 0;
  logic [LLEN-1:0] lhold = '0;
  bit              lknown = 1'b1;
  bit              last_stall, last_ready;

  task automatic chk(input string name, input logic [LLEN-1:0] act, input logic [LLEN-1:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [PA_BITS-1:0] a);
    return int'((a >> OFFSET) % WORDS);
  endfunction

  function automatic int bank_of(input logic [PA_BITS-1:0] a);
    return int'((a >> OFFSET) % NB);
  endfunction

  task automatic mdl_write(input logic [PA_BITS-1:0] a, input logic [LLEN-1:0] d,
                           input logic [NBYTES-1:0] m);
    int i;
    i = widx(a);
    for (int k = 0; k < NBYTES; k++) begin
      if (m[k]) mdl[i][8*k +: 8] = d[8*k +: 8];
    end
    if (m == {NBYTES{1'b1}}) known[i] = 1'b1;
  endtask

  // One clock: drive at the falling edge, check arbitration, then check returns.
  task automatic cycle(input logic ce, input logic fl, input logic [1:0] rw,
                       input logic [PA_BITS-1:0] la, input logic [LLEN-1:0] lw,
                       input logic [NBYTES-1:0] lm, input logic dv, input logic dw,
                       input logic [PA_BITS-1:0] da, input logic [LLEN-1:0] dwd,
                       input logic [NBYTES-1:0] dm);
    bit l_act, conflict, l_go, d_go, e_stall, e_ready, e_rv, dknown;
    logic [LLEN-1:0] e_dd;
    LsuCe = ce; FlushW = fl; LsuRW = rw; LsuAdr = la; LsuWData = lw; LsuBMask = lm;
    DmaValid = dv; DmaWrite = dw; DmaAdr = da; DmaWData = dwd; DmaBMask = dm;
    #1;
    l_act    = ce && (rw != 2'b00);
    conflict = l_act && dv && (bank_of(la) == bank_of(da));
    if (!conflict) begin
      l_go = l_act; d_go = dv; e_stall = 1'b0; e_ready = 1'b1; starve = 0;
    end else if (starve < SL) begin
      l_go = 1'b1; d_go = 1'b0; e_stall = 1'b0; e_ready = 1'b0; starve = starve + 1;
    end else begin
      l_go = 1'b0; d_go = 1'b1; e_stall = 1'b1; e_ready = 1'b1; starve = 0;
    end
    chk("lsu_stall", LsuStall, e_stall);
    chk("dma_ready", DmaReady, e_ready);
    last_stall = e_stall;
    last_ready = e_ready;
    if (l_go && rw[1]) begin
      lhold  = mdl[widx(la)];
      lknown = known[widx(la)];
    end
    e_rv   = d_go && !dw;
    e_dd   = mdl[widx(da)];
    dknown = known[widx(da)];
    if (l_go && rw[0] && !fl) mdl_write(la, lw, lm);
    if (d_go && dw) mdl_write(da, dwd, dm);
    @(posedge clk);
    @(negedge clk);
    if (lknown) chk("lsu_rdata", LsuReadData, lhold);
    chk("dma_rvalid", DmaRValid, e_rv);
    if (e_rv && dknown) chk("dma_rdata", DmaRData, e_dd);
    chk("parity_err", ParityErr, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  bit [5:0] rdy_h, stl_h;

  initial begin
    reset = 1'b1;
    LsuCe = 1'b0; FlushW = 1'b0; LsuRW = 2'b00; LsuAdr = '0; LsuWData = '0; LsuBMask = '0;
    DmaValid = 1'b0; DmaWrite = 1'b0; DmaAdr = '0; DmaWData = '0; DmaBMask = '0;
    for (int i = 0; i < WORDS; i++) begin
      mdl[i] = '0;
      known[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_lsu_rdata", LsuReadData, 64'h0);
    chk("rst_dma_rvalid", DmaRValid, 1'b0);
    chk("rst_parity", ParityErr, 1'b0);
    chk("rst_dma_rdata", DmaRData, 64'h0);
    reset = 1'b0;
    idle();

    // Fill words 0..31 so later reads have defined contents.
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, 1'b0, 2'b01, PA_BITS'(i * 8), {$urandom, $urandom}, 8'hFF,
            1'b0, 1'b0, '0, '0, '0);
    end

    // Write then read back the next cycle.
    cycle(1'b1, 1'b0, 2'b01, 32'h80, 64'h1122334455667788, 8'hFF, 1'b0, 1'b0, '0, '0, '0);
    cycle(1'b1, 1'b0, 2'b10, 32'h80, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    chk("rd_0x80", LsuReadData, 64'h1122334455667788);

    // Different banks in the same cycle: both proceed.
    cycle(1'b1, 1'b0, 2'b01, 32'h00, 64'hCAFEF00DDEADBEEF, 8'hFF, 1'b1, 1'b0, 32'h08, '0, '0);
    chk("diffbank_stall", {63'h0, last_stall}, 64'h0);
    chk("diffbank_ready", {63'h0, last_ready}, 64'h1);

    // Six cycles of same-bank conflict: DMA gets through on the fifth.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 2'b10, 32'h10, '0, '0, 1'b1, 1'b0, 32'h20, '0, '0);
      rdy_h[i] = last_ready;
      stl_h[i] = last_stall;
    end
    chk("starve_ready_hist", {58'h0, rdy_h}, 64'h10);
    chk("starve_stall_hist", {58'h0, stl_h}, 64'h10);

    // Flushed write must not store.
    cycle(1'b1, 1'b0, 2'b01, 32'h40, 64'hAAAAAAAAAAAAAAAA, 8'hFF, 1'b0, 1'b0, '0, '0, '0);
    cycle(1'b1, 1'b1, 2'b01, 32'h40, 64'h5555555555555555, 8'hFF, 1'b0, 1'b0, '0, '0, '0);
    cycle(1'b1, 1'b0, 2'b10, 32'h40, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    chk("flush_keeps_old", LsuReadData, 64'hAAAAAAAAAAAAAAAA);

    // Byte mask 0x0F: only the low four bytes change.
    cycle(1'b1, 1'b0, 2'b01, 32'h48, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0, 1'b0, '0, '0, '0);
    cycle(1'b1, 1'b0, 2'b01, 32'h48, 64'h0123456789ABCDEF, 8'h0F, 1'b0, 1'b0, '0, '0, '0);
    cycle(1'b1, 1'b0, 2'b10, 32'h48, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    chk("bmask_merge", LsuReadData, 64'hFFFFFFFF89ABCDEF);

    // LsuCe low holds the previous read word.
    idle();
    chk("ce_hold", LsuReadData, 64'hFFFFFFFF89ABCDEF);

    // Randomized mix of both requesters against the model.
    for (int n = 0; n < 300; n++) begin
      logic [1:0] rw;
      rw = 2'($urandom_range(0, 2));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rw,
            PA_BITS'($urandom_range(0, 31) * 8), {$urandom, $urandom}, NBYTES'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            PA_BITS'($urandom_range(0, 31) * 8), {$urandom, $urandom}, NBYTES'($urandom));
    end

    // Reset right after an accepted DMA read drops the response.
    LsuCe = 1'b0; LsuRW = 2'b00; DmaValid = 1'b1; DmaWrite = 1'b0; DmaAdr = 32'h08;
    #1;
    chk("pre_rst_ready", DmaReady, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1; DmaValid = 1'b0;
    @(negedge clk);
    chk("rst_drop_rvalid_0", DmaRValid, 1'b0);
    chk("rst_lsu_rdata_0", LsuReadData, 64'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_drop_rvalid_1", DmaRValid, 1'b0);
    reset = 1'b0;
    lhold = '0; lknown = 1'b1; starve = 0;
    idle();

`ifdef DTIM_PARITY_EN
    // Corrupt one stored bit behind the parity array's back, then read it.
    dut.g_bank[0].mem_q[1][0] = ~dut.g_bank[0].mem_q[1][0];
    mdl[2][0] = ~mdl[2][0];
    LsuCe = 1'b1; LsuRW = 2'b10; LsuAdr = 32'h10; DmaValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("parity_pulse", ParityErr, 1'b1);
    chk("parity_data", LsuReadData, mdl[2]);
    LsuCe = 1'b0; LsuRW = 2'b00;
    @(posedge clk);
    @(negedge clk);
    chk("parity_clear", ParityErr, 1'b0);
    lhold = mdl[2];
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
